// File: rtl/program_loader.sv
// Boot loader: UART byte stream -> little-endian words -> program memory writes.
// Holds the core in reset until a complete, valid image has been written.
module program_loader #(
  parameter int MEM_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        pmem_we,
  output logic [31:0] pmem_addr,
  output logic [31:0] pmem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        load_done,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_WAIT_LEN,
    S_LOAD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t        r_state;
  logic [1:0]    r_bcnt;
  logic [23:0]   r_shift;
  logic [31:0]   r_len;
  logic [TW-1:0] r_to;

  logic [31:0]   w_word;
  logic          w_last;
  logic          w_active;
  logic          w_to_en;
  logic          w_to_hit;
  logic [16:0]   w_words_inc;
  logic [15:0]   w_words_sat;
  logic          w_done;
  logic          w_bad_len;

  // Newest byte enters at the top, so byte k ends up in bits [8k+7:8k].
  assign w_word      = {rx_data, r_shift};
  assign w_last      = (r_bcnt == 2'd3);
  assign w_active    = (r_state == S_WAIT_LEN) || (r_state == S_LOAD);
  assign w_to_en     = (r_state == S_LOAD) ||
                       ((r_state == S_WAIT_LEN) && (r_bcnt != 2'd0));
  assign w_to_hit    = (r_to == TW'(TIMEOUT_CYCLES - 1));
  assign w_words_inc = {1'b0, words_loaded} + 17'd1;
  assign w_words_sat = w_words_inc[16] ? 16'hFFFF : w_words_inc[15:0];
  assign w_done      = ({15'd0, w_words_inc} == r_len);
  assign w_bad_len   = (w_word == 32'd0) || (w_word > 32'(MEM_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_WAIT_LEN;
      r_bcnt       <= '0;
      r_shift      <= '0;
      r_len        <= '0;
      r_to         <= '0;
      pmem_we      <= 1'b0;
      pmem_addr    <= '0;
      pmem_wdata   <= '0;
      cpu_rst      <= 1'b1;
      busy         <= 1'b1;
      load_done    <= 1'b0;
      err_code     <= 2'b00;
      words_loaded <= '0;
    end else begin
      pmem_we <= 1'b0;
      cpu_rst <= (r_state != S_RUN);
      if (load_req) begin
        r_state      <= S_WAIT_LEN;
        r_bcnt       <= '0;
        r_to         <= '0;
        words_loaded <= '0;
        err_code     <= 2'b00;
        cpu_rst      <= 1'b1;
        busy         <= 1'b1;
        load_done    <= 1'b0;
      end else if (w_active) begin
        if (rx_valid) begin
          r_to    <= '0;
          r_bcnt  <= r_bcnt + 2'd1;
          r_shift <= w_word[31:8];
          if (w_last) begin
            if (r_state == S_WAIT_LEN) begin
              if (w_bad_len) begin
                r_state  <= S_ERROR;
                err_code <= 2'b01;
                busy     <= 1'b0;
              end else begin
                r_state <= S_LOAD;
                r_len   <= w_word;
              end
            end else begin
              pmem_we      <= 1'b1;
              pmem_wdata   <= w_word;
              pmem_addr    <= {14'd0, words_loaded, 2'b00};
              words_loaded <= w_words_sat;
              if (w_done) begin
                r_state   <= S_RUN;
                busy      <= 1'b0;
                load_done <= 1'b1;
              end
            end
          end
        end else if (w_to_en) begin
          if (w_to_hit) begin
            r_state  <= S_ERROR;
            err_code <= 2'b10;
            busy     <= 1'b0;
            r_bcnt   <= '0;
            r_to     <= '0;
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a short byte timeout.
// Writes are captured at the falling edge and compared against hand-built images.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        pmem_we;
  logic [31:0] pmem_addr;
  logic [31:0] pmem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        load_done;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  always #5 clk = ~clk;

  program_loader #(
    .MEM_WORDS(1024),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_req(load_req),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .pmem_we(pmem_we),
    .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata),
    .cpu_rst(cpu_rst),
    .busy(busy),
    .load_done(load_done),
    .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always @(negedge clk) begin
    if (pmem_we === 1'b1) begin
      q_addr.push_back(pmem_addr);
      q_data.push_back(pmem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    int bad;
    rst      = 1'b1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(err_code), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_we", 32'(pmem_we), 32'd0);
    chk("rst_addr", pmem_addr, 32'd0);
    chk("rst_wdata", pmem_wdata, 32'd0);
    rst = 1'b0;

    // basic two-word image
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_byte(8'h93);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    chk("t1_done_early", 32'(load_done), 32'd1);
    chk("t1_cpu_rst_hold", 32'(cpu_rst), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t1_cpu_rst_fall", 32'(cpu_rst), 32'd0);
    chk("t1_nwr", 32'(q_addr.size()), 32'd2);
    chk("t1_a0", q_addr[0], 32'h0);
    chk("t1_d0", q_data[0], 32'h0000_0013);
    chk("t1_a1", q_addr[1], 32'h4);
    chk("t1_d1", q_data[1], 32'h0010_0093);
    chk("t1_words", 32'(words_loaded), 32'd2);
    chk("t1_we_low", 32'(pmem_we), 32'd0);
    chk("t1_addr_hold", pmem_addr, 32'h4);

    // bytes in RUN are ignored
    send_word(32'h4433_2211);
    idle(2);
    chk("t5_nwr", 32'(q_addr.size()), 32'd2);
    chk("t5_words", 32'(words_loaded), 32'd2);
    chk("t5_done", 32'(load_done), 32'd1);

    // load_req beats a simultaneous byte
    @(negedge clk);
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    @(negedge clk);
    load_req = 1'b0;
    rx_valid = 1'b0;
    chk("t5_lr_busy", 32'(busy), 32'd1);
    chk("t5_lr_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t5_lr_done", 32'(load_done), 32'd0);
    chk("t5_lr_words", 32'(words_loaded), 32'd0);
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    @(negedge clk);
    chk("t5_done2", 32'(load_done), 32'd1);
    chk("t5_nwr2", 32'(q_addr.size()), 32'd3);
    chk("t5_a", q_addr[2], 32'h0);
    chk("t5_d", q_data[2], 32'hDEAD_BEEF);

    // zero length
    pulse_load();
    base = q_addr.size();
    send_word(32'd0);
    idle(5);
    chk("t2_err", 32'(err_code), 32'd1);
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t2_done", 32'(load_done), 32'd0);
    chk("t2_nwr", 32'(q_addr.size()), 32'(base));
    pulse_load();
    chk("t2_clr_err", 32'(err_code), 32'd0);
    chk("t2_clr_busy", 32'(busy), 32'd1);

    // length one past capacity, then exactly capacity
    send_word(32'd1025);
    idle(2);
    chk("t3_err_big", 32'(err_code), 32'd1);
    pulse_load();
    base = q_addr.size();
    send_word(32'd1024);
    for (int j = 0; j < 1024; j++) send_word(32'hA500_0000 ^ 32'(j));
    idle(2);
    chk("t3_nwr", 32'(q_addr.size() - base), 32'd1024);
    bad = 0;
    for (int j = 0; j < 1024; j++) begin
      if (q_addr[base + j] !== 32'(4 * j)) bad++;
      if (q_data[base + j] !== (32'hA500_0000 ^ 32'(j))) bad++;
    end
    chk("t3_contents", 32'(bad), 32'd0);
    chk("t3_last_addr", q_addr[q_addr.size() - 1], 32'hFFC);
    chk("t3_words", 32'(words_loaded), 32'd1024);
    chk("t3_done", 32'(load_done), 32'd1);
    chk("t3_err", 32'(err_code), 32'd0);

    // timeout inside a partial word
    pulse_load();
    base = q_addr.size();
    send_word(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(90);
    chk("t4_no_err_yet", 32'(err_code), 32'd0);
    chk("t4_busy_yet", 32'(busy), 32'd1);
    idle(20);
    chk("t4_err", 32'(err_code), 32'd2);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t4_nwr", 32'(q_addr.size()), 32'(base));
    pulse_load();
    idle(1000);
    chk("t4_idle_err", 32'(err_code), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd1);

    // async reset mid-image
    send_word(32'd2);
    send_byte(8'h13);
    send_byte(8'h00);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_addr", pmem_addr, 32'h0);
    chk("t6_wdata", pmem_wdata, 32'h0);
    chk("t6_busy", 32'(busy), 32'd1);
    chk("t6_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("t6_done", 32'(load_done), 32'd0);
    idle(2);
    rst = 1'b0;
    base = q_addr.size();
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    idle(2);
    chk("t6_nwr", 32'(q_addr.size() - base), 32'd2);
    chk("t6_a0", q_addr[base], 32'h0);
    chk("t6_d0", q_data[base], 32'h0000_0013);
    chk("t6_a1", q_addr[base + 1], 32'h4);
    chk("t6_d1", q_data[base + 1], 32'h0010_0093);
    chk("t6_done2", 32'(load_done), 32'd1);
    chk("t6_cpu_run", 32'(cpu_rst), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
